// File: rtl/ldpc_ram_pkg.sv
// rtl/ldpc_ram_pkg.sv - shared types and address rotation for LDPC RAM port controllers
//
// Contents:
//   port_state_e : IDLE / LOAD / RUN state of a RAM port controller
//   rot_addr()   : cyclic rotation of a logical column address by shift s modulo z

package ldpc_ram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } port_state_e;

   // Subtract-and-wrap instead of a modulo so non-power-of-two z stays cheap.
   // Caller guarantees s < z.
   function automatic int unsigned rot_addr(input int unsigned a,
                                            input int unsigned s,
                                            input int unsigned z);
      if (a >= s) begin
         return a - s;
      end
      return a + z - s;
   endfunction

endpackage

// File: rtl/cyc_addr_rot.sv
// rtl/cyc_addr_rot.sv - combinational cyclic address rotation for one RAM column
//
// Parameters: Z lifting factor (2..256)
// Ports:
//   shift     in  AW+1  raw expansion shift; values >= Z are treated as 0
//   log_addr  in  AW    logical address
//   phys_addr out AW    rotated physical address

module cyc_addr_rot
   import ldpc_ram_pkg::*;
#(
   parameter  int Z  = 64,
   localparam int AW = $clog2(Z),
   localparam int SW = AW + 1
) (
   input  logic [SW-1:0] shift,
   input  logic [AW-1:0] log_addr,
   output logic [AW-1:0] phys_addr
);

   localparam logic [SW-1:0] Z_SW = SW'(Z);

   logic [AW-1:0] s_eff;

   always_comb begin
      s_eff = '0;
      if (shift < Z_SW) begin
         s_eff = shift[AW-1:0];
      end
      phys_addr = AW'(rot_addr(32'(log_addr), 32'(s_eff), Z));
   end

endmodule

// File: rtl/ram_port_shift_ctrl.sv
// rtl/ram_port_shift_ctrl.sv - RAM port controller: original-LLR load then VFU access, with cyclic address shift
//
// Optional macro: RAM_PORT_ERR_CHK_EN enables the sticky err detector (otherwise err = 0).
// Parameters: Z lifting factor (RAM depth), DW data width
// Ports:
//   sys_clk, sys_rst_n                      clock, synchronous active-low reset
//   flag_first_store                        pulse: start (or restart) the load phase
//   org_addr/org_data/org_wr_en             original-LLR write stream (used in LOAD)
//   vfu_addr/vfu_data/vfu_wr_en/vfu_rd_en   VFU access (used in RUN)
//   cyclic_shif                             expansion shift for this RAM
//   ram_addr/ram_data/ram_wr_en/ram_rd_en   registered RAM port
//   load_busy, load_done, vfu_stall, err    status

module ram_port_shift_ctrl
   import ldpc_ram_pkg::*;
#(
   parameter  int Z  = 64,
   parameter  int DW = 4,
   localparam int AW = $clog2(Z),
   localparam int SW = AW + 1
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          flag_first_store,
   input  logic [AW-1:0] org_addr,
   input  logic [DW-1:0] org_data,
   input  logic          org_wr_en,
   input  logic [AW-1:0] vfu_addr,
   input  logic [DW-1:0] vfu_data,
   input  logic          vfu_wr_en,
   input  logic          vfu_rd_en,
   input  logic [SW-1:0] cyclic_shif,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_data,
   output logic          ram_wr_en,
   output logic          ram_rd_en,
   output logic          load_busy,
   output logic          load_done,
   output logic          vfu_stall,
   output logic          err
);

   localparam logic [SW-1:0] LAST_CNT = SW'(Z - 1);

   port_state_e   state_q, state_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_data_q, ram_data_d;
   logic          ram_wr_en_q, ram_wr_en_d;
   logic          ram_rd_en_q, ram_rd_en_d;
   logic          load_done_c;
   logic          vfu_stall_c;
   logic [AW-1:0] sel_addr;
   logic [AW-1:0] phys_addr;

   // One rotator is shared: only one source can own the port in any state.
   assign sel_addr = (state_q == ST_LOAD) ? org_addr : vfu_addr;

   cyc_addr_rot #(.Z(Z)) u_rot (
      .shift     (cyclic_shif),
      .log_addr  (sel_addr),
      .phys_addr (phys_addr)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ram_addr_d  = ram_addr_q;
      ram_data_d  = ram_data_q;
      ram_wr_en_d = 1'b0;
      ram_rd_en_d = 1'b0;
      load_done_c = 1'b0;
      vfu_stall_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (flag_first_store) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end

         ST_LOAD: begin
            vfu_stall_c = vfu_wr_en | vfu_rd_en;
            if (org_wr_en) begin
               ram_wr_en_d = 1'b1;
               ram_addr_d  = phys_addr;
               ram_data_d  = org_data;
            end
            // A restart pulse discards progress; a write in that same cycle
            // still reaches the RAM but does not count toward completion.
            if (flag_first_store) begin
               cnt_d = '0;
            end else if (org_wr_en) begin
               if (cnt_q == LAST_CNT) begin
                  state_d     = ST_RUN;
                  cnt_d       = '0;
                  load_done_c = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (vfu_wr_en) begin
               ram_wr_en_d = 1'b1;
               ram_addr_d  = phys_addr;
               ram_data_d  = vfu_data;
            end else if (vfu_rd_en) begin
               ram_rd_en_d = 1'b1;
               ram_addr_d  = phys_addr;
            end
            if (flag_first_store) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // A load cut short by reset must not report completion.
      if (!sys_rst_n) begin
         load_done_c = 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
         ram_wr_en_q <= 1'b0;
         ram_rd_en_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ram_addr_q  <= ram_addr_d;
         ram_data_q  <= ram_data_d;
         ram_wr_en_q <= ram_wr_en_d;
         ram_rd_en_q <= ram_rd_en_d;
      end
   end

`ifdef RAM_PORT_ERR_CHK_EN
   localparam logic [SW-1:0] Z_SW = SW'(Z);

   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if ((cyclic_shif >= Z_SW) && (org_wr_en | vfu_wr_en | vfu_rd_en)) begin
         err_d = 1'b1;
      end
      if ((state_q == ST_LOAD) && (vfu_wr_en | vfu_rd_en)) begin
         err_d = 1'b1;
      end
      if (vfu_wr_en & vfu_rd_en) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign ram_addr  = ram_addr_q;
   assign ram_data  = ram_data_q;
   assign ram_wr_en = ram_wr_en_q;
   assign ram_rd_en = ram_rd_en_q;
   assign load_busy = (state_q == ST_LOAD);
   assign load_done = load_done_c;
   assign vfu_stall = vfu_stall_c;

endmodule

// File: tb/tb_ram_port_shift_ctrl.sv
// tb/tb_ram_port_shift_ctrl.sv - scoreboard bench for ram_port_shift_ctrl (Z=64 and Z=48 instances)

module tb_ram_port_shift_ctrl;

   localparam int Z  = 64;
   localparam int DW = 4;
   localparam int AW = 6;
   localparam int SW = 7;

`ifdef RAM_PORT_ERR_CHK_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic          sys_clk;
   logic          sys_rst_n;
   logic          flag_first_store;
   logic [AW-1:0] org_addr;
   logic [DW-1:0] org_data;
   logic          org_wr_en;
   logic [AW-1:0] vfu_addr;
   logic [DW-1:0] vfu_data;
   logic          vfu_wr_en;
   logic          vfu_rd_en;
   logic [SW-1:0] cyclic_shif;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic          ram_wr_en;
   logic          ram_rd_en;
   logic          load_busy;
   logic          load_done;
   logic          vfu_stall;
   logic          err;

   logic          b_flag;
   logic [5:0]    b_org_addr;
   logic [3:0]    b_org_data;
   logic          b_org_wr_en;
   logic [6:0]    b_cyclic_shif;
   logic [5:0]    b_ram_addr;
   logic [3:0]    b_ram_data;
   logic          b_ram_wr_en;
   logic          b_ram_rd_en;
   logic          b_load_busy;
   logic          b_load_done;
   logic          b_vfu_stall;
   logic          b_err;

   ram_port_shift_ctrl #(.Z(Z), .DW(DW)) dut (
      .sys_clk          (sys_clk),
      .sys_rst_n        (sys_rst_n),
      .flag_first_store (flag_first_store),
      .org_addr         (org_addr),
      .org_data         (org_data),
      .org_wr_en        (org_wr_en),
      .vfu_addr         (vfu_addr),
      .vfu_data         (vfu_data),
      .vfu_wr_en        (vfu_wr_en),
      .vfu_rd_en        (vfu_rd_en),
      .cyclic_shif      (cyclic_shif),
      .ram_addr         (ram_addr),
      .ram_data         (ram_data),
      .ram_wr_en        (ram_wr_en),
      .ram_rd_en        (ram_rd_en),
      .load_busy        (load_busy),
      .load_done        (load_done),
      .vfu_stall        (vfu_stall),
      .err              (err)
   );

   ram_port_shift_ctrl #(.Z(48), .DW(4)) dut48 (
      .sys_clk          (sys_clk),
      .sys_rst_n        (sys_rst_n),
      .flag_first_store (b_flag),
      .org_addr         (b_org_addr),
      .org_data         (b_org_data),
      .org_wr_en        (b_org_wr_en),
      .vfu_addr         (6'd0),
      .vfu_data         (4'd0),
      .vfu_wr_en        (1'b0),
      .vfu_rd_en        (1'b0),
      .cyclic_shif      (b_cyclic_shif),
      .ram_addr         (b_ram_addr),
      .ram_data         (b_ram_data),
      .ram_wr_en        (b_ram_wr_en),
      .ram_rd_en        (b_ram_rd_en),
      .load_busy        (b_load_busy),
      .load_done        (b_load_done),
      .vfu_stall        (b_vfu_stall),
      .err              (b_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic          wr;
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   int            total = 0;
   int            bad   = 0;
   int            done_cnt;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   // Expected RAM port after the next edge; address/data hold when idle.
   task automatic expect_ram(input logic wr, input logic rd,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      if (wr) begin
         m_addr = a;
         m_data = d;
      end else if (rd) begin
         m_addr = a;
      end
      e.wr   = wr;
      e.rd   = rd;
      e.addr = m_addr;
      e.data = m_data;
      sb.push_back(e);
   endtask

   task automatic expect_reset();
      m_addr = '0;
      m_data = '0;
      expect_ram(1'b0, 1'b0, '0, '0);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge sys_clk);
      #1;
      chk("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("ram_wr_en", ram_wr_en, e.wr);
         chk("ram_rd_en", ram_rd_en, e.rd);
         chk("ram_addr", ram_addr, e.addr);
         chk("ram_data", ram_data, e.data);
      end
   endtask

   task automatic do_load(input int n, input int s);
      cyclic_shif = SW'(s);
      for (int i = 0; i < n; i++) begin
         org_wr_en = 1'b1;
         org_addr  = AW'(i);
         org_data  = DW'(i);
         #1;
         if (load_done) done_cnt++;
         chk("load_done", load_done, (i == Z - 1));
         expect_ram(1'b1, 1'b0, AW'((i + Z - s) % Z), DW'(i));
         tick();
      end
      org_wr_en = 1'b0;
   endtask

   initial begin
      sys_rst_n        = 1'b0;
      flag_first_store = 1'b0;
      org_addr         = '0;
      org_data         = '0;
      org_wr_en        = 1'b0;
      vfu_addr         = '0;
      vfu_data         = '0;
      vfu_wr_en        = 1'b0;
      vfu_rd_en        = 1'b0;
      cyclic_shif      = '0;
      b_flag           = 1'b0;
      b_org_addr       = '0;
      b_org_data       = '0;
      b_org_wr_en      = 1'b0;
      b_cyclic_shif    = '0;
      m_addr           = '0;
      m_data           = '0;
      done_cnt         = 0;
      #1;
      repeat (2) begin
         expect_reset();
         tick();
      end
      chk("rst_load_busy", load_busy, 0);
      chk("rst_load_done", load_done, 0);
      chk("rst_vfu_stall", vfu_stall, 0);
      chk("rst_err", err, 0);
      sys_rst_n = 1'b1;

      // IDLE: no enables from either source, no stall
      org_wr_en = 1'b1; org_addr = 6'd9; org_data = 4'd3;
      vfu_rd_en = 1'b1; vfu_addr = 6'd4;
      #1;
      chk("idle_stall", vfu_stall, 0);
      expect_ram(1'b0, 1'b0, '0, '0);
      tick();
      chk("idle_busy", load_busy, 0);
      org_wr_en = 1'b0; vfu_rd_en = 1'b0;

      // Full load with s=5: 59..63,0..58
      flag_first_store = 1'b1;
      expect_ram(1'b0, 1'b0, '0, '0);
      tick();
      flag_first_store = 1'b0;
      chk("load_busy", load_busy, 1);
      done_cnt = 0;
      do_load(64, 5);
      chk("done_count_a", done_cnt, 1);
      chk("run_busy", load_busy, 0);

      // RUN: VFU reads/writes through the rotator
      vfu_rd_en = 1'b1; vfu_addr = 6'd3; cyclic_shif = 7'd10;
      #1;
      chk("run_stall", vfu_stall, 0);
      expect_ram(1'b0, 1'b1, 6'd57, '0);
      tick();
      cyclic_shif = 7'd0;
      expect_ram(1'b0, 1'b1, 6'd3, '0);
      tick();
      vfu_rd_en = 1'b0; vfu_wr_en = 1'b1; vfu_addr = 6'd20; vfu_data = 4'hA; cyclic_shif = 7'd10;
      expect_ram(1'b1, 1'b0, 6'd10, 4'hA);
      tick();
      vfu_wr_en = 1'b0; org_wr_en = 1'b1; org_addr = 6'd1; org_data = 4'd6;
      expect_ram(1'b0, 1'b0, '0, '0);
      tick();
      org_wr_en = 1'b0;
      expect_ram(1'b0, 1'b0, '0, '0);
      tick();
      chk("err_clean", err, 0);

      // VFU request during LOAD is dropped and flagged
      flag_first_store = 1'b1;
      expect_ram(1'b0, 1'b0, '0, '0);
      tick();
      flag_first_store = 1'b0;
      chk("reload_busy", load_busy, 1);
      vfu_wr_en = 1'b1; vfu_addr = 6'd2; vfu_data = 4'd7;
      #1;
      chk("load_stall_wr", vfu_stall, 1);
      expect_ram(1'b0, 1'b0, '0, '0);
      tick();
      vfu_wr_en = 1'b0;
      chk("err_load_vfu", err, ERR_ON);
      vfu_rd_en = 1'b1;
      #1;
      chk("load_stall_rd", vfu_stall, 1);
      expect_ram(1'b0, 1'b0, '0, '0);
      tick();
      vfu_rd_en = 1'b0;

      // Reset in the middle of a load
      do_load(30, 0);
      sys_rst_n = 1'b0; org_wr_en = 1'b1; org_addr = 6'd30; org_data = 4'd2;
      #1;
      chk("rst_mid_done", load_done, 0);
      expect_reset();
      tick();
      sys_rst_n = 1'b1; org_wr_en = 1'b0;
      chk("rst_mid_busy", load_busy, 0);
      chk("rst_mid_err", err, 0);

      // Fresh load after reset: exactly one load_done
      flag_first_store = 1'b1;
      expect_ram(1'b0, 1'b0, '0, '0);
      tick();
      flag_first_store = 1'b0;
      done_cnt = 0;
      do_load(64, 63);
      chk("done_count_b", done_cnt, 1);
      chk("run_busy_b", load_busy, 0);

      // Simultaneous VFU write and read: write wins
      vfu_wr_en = 1'b1; vfu_rd_en = 1'b1; vfu_addr = 6'd7; vfu_data = 4'd5; cyclic_shif = 7'd0;
      expect_ram(1'b1, 1'b0, 6'd7, 4'd5);
      tick();
      vfu_wr_en = 1'b0; vfu_rd_en = 1'b0;
      chk("err_wr_rd", err, ERR_ON);

      // flag_first_store inside LOAD restarts the write count
      flag_first_store = 1'b1;
      expect_ram(1'b0, 1'b0, '0, '0);
      tick();
      flag_first_store = 1'b0;
      do_load(10, 0);
      flag_first_store = 1'b1;
      expect_ram(1'b0, 1'b0, '0, '0);
      tick();
      flag_first_store = 1'b0;
      done_cnt = 0;
      do_load(64, 0);
      chk("done_count_c", done_cnt, 1);

      // Z=48 instance: non-power-of-two wrap and out-of-range shift
      b_flag = 1'b1;
      @(posedge sys_clk); #1;
      b_flag = 1'b0;
      chk("z48_busy", b_load_busy, 1);
      b_org_wr_en = 1'b1; b_org_addr = 6'd0; b_org_data = 4'd9; b_cyclic_shif = 7'd47;
      @(posedge sys_clk); #1;
      chk("z48_wr", b_ram_wr_en, 1);
      chk("z48_rd", b_ram_rd_en, 0);
      chk("z48_addr_a0", b_ram_addr, 1);
      chk("z48_data", b_ram_data, 9);
      chk("z48_err_ok", b_err, 0);
      b_org_addr = 6'd46;
      @(posedge sys_clk); #1;
      chk("z48_addr_a46", b_ram_addr, 47);
      b_cyclic_shif = 7'd50; b_org_addr = 6'd5;
      @(posedge sys_clk); #1;
      chk("z48_addr_oor", b_ram_addr, 5);
      chk("z48_err_oor", b_err, ERR_ON);
      b_org_wr_en = 1'b0;

      chk("sb_left", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_port_shift_ctrl.md
RAM_PORT_SHIFT_CTRL -- requirements
Module: ram_port_shift_ctrl

Interface
REQ-001 SHALL have parameter Z, default 64, the lifting factor (RAM depth per block column, 2..256).
REQ-002 SHALL have parameter DW, default 4, the LLR/message data width.
REQ-003 SHALL have derived local widths AW=clog2(Z) for addresses and SW=AW+1 for the shift value.
REQ-004 SHALL have port sys_clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port sys_rst_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port flag_first_store, input, 1, a pulse that starts the original-LLR load phase.
REQ-007 SHALL have ports org_addr/org_data/org_wr_en, inputs, AW/DW/1, the original-LLR write stream.
REQ-008 SHALL have ports vfu_addr/vfu_data/vfu_wr_en/vfu_rd_en, inputs, AW/DW/1/1, the VFU access.
REQ-009 SHALL have port cyclic_shif, input, SW, the H-matrix expansion shift for this RAM.
REQ-010 SHALL have outputs ram_addr AW, ram_data DW, ram_wr_en 1 and ram_rd_en 1, the RAM port.
REQ-011 SHALL have outputs load_busy 1 (high in LOAD), load_done 1 (one-cycle pulse) and vfu_stall 1 (VFU request dropped).
REQ-012 SHALL have output err, 1, a sticky error flag.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD and RUN.
REQ-014 SHALL move IDLE->LOAD and RUN->LOAD on flag_first_store; flag_first_store in LOAD restarts the write counter at 0.
REQ-015 SHALL count accepted org writes in LOAD, i.e. org_wr_en=1 cycles, with counter width AW+1.
REQ-016 SHALL go LOAD->RUN on the cycle of the Z-th accepted write, pulse load_done that cycle, and not depend on org_addr value.
REQ-017 SHALL source the RAM from org only in LOAD and from VFU only in RUN; org_wr_en outside LOAD is ignored; IDLE drives no enables.
REQ-018 SHALL drop VFU requests in LOAD and set vfu_stall=1 combinationally for that cycle when vfu_wr_en|vfu_rd_en.
REQ-019 SHALL compute shift s = cyclic_shif when cyclic_shif<Z, else 0.
REQ-020 SHALL map the selected logical address a to physical address (a>=s) ? a-s : a+Z-s, for every Z including non-powers of two.
REQ-021 SHALL register all ram_* outputs, giving 1-cycle latency from the input cycle to the RAM port.
REQ-022 SHALL hold ram_rd_en=0 whenever ram_wr_en=1.
REQ-023 SHALL give VFU write priority over read when vfu_wr_en and vfu_rd_en are both high: read suppressed, write issued.
REQ-024 SHALL hold ram_addr/ram_data at their last value when no enable is issued.

Reset
REQ-025 SHALL, on sys_rst_n=0 at a clock edge, set state=IDLE, counter=0, all ram_* outputs=0, load_busy=0, load_done=0, err=0.
REQ-026 SHALL abandon a LOAD interrupted by reset; no load_done is produced.

Configuration
REQ-027 SHALL, with macro RAM_PORT_ERR_CHK_EN defined, set err sticky (cleared only by reset) on: cyclic_shif>=Z while an enable is requested, VFU request in LOAD, or simultaneous VFU wr+rd.
REQ-028 SHALL, without RAM_PORT_ERR_CHK_EN, tie err to 0 and omit the check logic; all other behaviour is unchanged.

Structure
REQ-029 SHALL place the FSM state enum and the address-rotation function in shared package ldpc_ram_pkg.
REQ-030 SHALL implement the address rotation as one combinational sub-module, cyc_addr_rot (parameter Z), reusable by other port controllers.

Verification (Z=64, DW=4 unless noted)
REQ-031 SHALL cover: flag_first_store, then 64 org writes addr 0..63 with s=5 -> ram_addr 59,60,61,62,63,0,1..58 one cycle later; load_done on the 64th write; then RUN.
REQ-032 SHALL cover: RUN, vfu_rd_en, vfu_addr=3, s=10 -> next cycle ram_rd_en=1, ram_addr=57; with s=0 -> ram_addr=3.
REQ-033 SHALL cover: vfu_wr_en during LOAD -> vfu_stall=1, no RAM write, err=1 (macro on) or err=0 (macro off).
REQ-034 SHALL cover: vfu_wr_en=vfu_rd_en=1, vfu_addr=7, s=0 -> ram_wr_en=1, ram_rd_en=0, ram_addr=7; err=1 with the macro on.
REQ-035 SHALL cover: reset asserted after 30 load writes -> outputs zero and state IDLE; new flag plus 64 writes -> exactly one load_done.
REQ-036 SHALL cover: Z=48, s=47, a=0 -> ram_addr=1; cyclic_shif=50 -> s treated as 0 and err=1 (macro on).
